// File: rtl/elastic_config_loader.sv
// elastic_config_loader: streams config words into an ElasticPE array over a shared
// broadcast bus (one-hot write strobe per PE), then pulses start_exec, times the run
// and reports done / bad-word errors.
// Optional feature: define CONFIG_LOADER_PERF_EN to add perf_run_cycles, a saturating
// count of cycles spent in RUN (cleared on each accepted cmd_load).
module elastic_config_loader #(
   parameter int PE_NUM                     = 16,
   parameter int PE_ID_WIDTH                = 4,
   parameter int NEIGHBOR_PE_NUM            = 4,
   parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = 2,
   parameter int OPERATION_BIT_LENGTH       = 4,
   parameter int DATA_WIDTH                 = 32,
   parameter int CONTEXT_SIZE_BIT_LENGTH    = 3,
   parameter int WORD_CNT_WIDTH             = 16,
   parameter int RUN_CNT_WIDTH              = 32
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  cmd_load,
   input  logic [WORD_CNT_WIDTH-1:0]             cmd_word_count,
   input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cmd_context_max_id,
   input  logic [RUN_CNT_WIDTH-1:0]              cmd_run_cycles,
   input  logic                                  cmd_abort,
   input  logic                                  cfg_valid_input,
   output logic                                  cfg_stop_input,
   input  logic [PE_ID_WIDTH-1:0]                cfg_pe_id,
   input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cfg_context_index,
   input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_1,
   input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_2,
   input  logic [NEIGHBOR_PE_NUM-1:0]            cfg_output_PE_index,
   input  logic [OPERATION_BIT_LENGTH-1:0]       cfg_op,
   input  logic [DATA_WIDTH-1:0]                 cfg_const_data,
   output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
   output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
   output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
   output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
   output logic [DATA_WIDTH-1:0]                 config_const_data,
   output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
   output logic [PE_NUM-1:0]                     write_config_data,
   output logic                                  start_exec,
   output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
   output logic                                  busy,
   output logic                                  done,
`ifdef CONFIG_LOADER_PERF_EN
   output logic [RUN_CNT_WIDTH-1:0]              perf_run_cycles,
`endif
   output logic                                  err_bad_word
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FLUSH = 3'd2,
      S_START = 3'd3,
      S_RUN   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                      r_state, w_next;
   logic [WORD_CNT_WIDTH-1:0]   r_word_cnt;
   logic [RUN_CNT_WIDTH-1:0]    r_run_cnt;
   logic                        w_accept;
   logic                        w_xfer;
   logic                        w_bad;
   logic [PE_NUM-1:0]           w_onehot;

   // A new sequence is only taken from IDLE; abort in the same cycle wins.
   assign w_accept = (r_state == S_IDLE) && cmd_load && !cmd_abort;
   // Stop is low exactly in LOAD, so a transfer is valid while in LOAD.
   assign w_xfer   = (r_state == S_LOAD) && cfg_valid_input;
   assign w_bad    = (32'(cfg_pe_id) >= PE_NUM) || (cfg_context_index > mapping_context_max_id);
   assign w_onehot = PE_NUM'(1) << cfg_pe_id;
   assign busy     = (r_state != S_IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state and state-decoded handshake/pulse outputs.
   always_comb begin
      w_next         = r_state;
      cfg_stop_input = 1'b1;
      start_exec     = 1'b0;
      done           = 1'b0;
      case (r_state)
         S_IDLE:  if (w_accept && (cmd_word_count != '0)) w_next = S_LOAD;
         S_LOAD: begin
            cfg_stop_input = 1'b0;
            if (w_xfer && (r_word_cnt == WORD_CNT_WIDTH'(1))) w_next = S_FLUSH;
         end
         S_FLUSH: w_next = S_START;
         S_START: begin
            start_exec = !cmd_abort;
            w_next     = S_RUN;
         end
         S_RUN:   if (r_run_cnt == RUN_CNT_WIDTH'(1)) w_next = S_DONE;
         S_DONE: begin
            done   = !cmd_abort;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (cmd_abort) w_next = S_IDLE;
   end

   // Latch run parameters on accept; count words during LOAD and cycles during RUN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_word_cnt             <= '0;
         r_run_cnt              <= '0;
         mapping_context_max_id <= '0;
      end else if (w_accept && (cmd_word_count != '0)) begin
         r_word_cnt             <= cmd_word_count;
         r_run_cnt              <= cmd_run_cycles;
         mapping_context_max_id <= cmd_context_max_id;
      end else begin
         if (w_xfer) r_word_cnt <= r_word_cnt - WORD_CNT_WIDTH'(1);
         if ((r_state == S_RUN) && (r_run_cnt != '0)) r_run_cnt <= r_run_cnt - RUN_CNT_WIDTH'(1);
      end
   end

   // Broadcast bus holds its last word; the strobe is a one-cycle echo of a good transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         config_input_PE_index_1 <= '0;
         config_input_PE_index_2 <= '0;
         config_output_PE_index  <= '0;
         config_op               <= '0;
         config_const_data       <= '0;
         config_index            <= '0;
         write_config_data       <= '0;
      end else begin
         write_config_data <= (w_xfer && !w_bad) ? w_onehot : '0;
         if (w_xfer) begin
            config_input_PE_index_1 <= cfg_input_PE_index_1;
            config_input_PE_index_2 <= cfg_input_PE_index_2;
            config_output_PE_index  <= cfg_output_PE_index;
            config_op               <= cfg_op;
            config_const_data       <= cfg_const_data;
            config_index            <= cfg_context_index;
         end
      end
   end

   // Sticky error: cleared by a good load request, set by empty request or bad word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                      err_bad_word <= 1'b0;
      else if (w_accept && (cmd_word_count == '0))       err_bad_word <= 1'b1;
      else if (w_accept)                                 err_bad_word <= 1'b0;
      else if (w_xfer && w_bad)                          err_bad_word <= 1'b1;
   end

`ifdef CONFIG_LOADER_PERF_EN
   // Saturating count of RUN cycles for the most recent sequence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                            perf_run_cycles <= '0;
      else if (w_accept && (cmd_word_count != '0))             perf_run_cycles <= '0;
      else if ((r_state == S_RUN) && (perf_run_cycles != '1))  perf_run_cycles <= perf_run_cycles + RUN_CNT_WIDTH'(1);
   end
`endif

endmodule

// File: tb/tb_elastic_config_loader.sv
// Scoreboard bench for elastic_config_loader: stimulus pushes expected strobe/bus
// values, a negedge monitor pops and compares whenever a write strobe appears.
module tb_elastic_config_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_load = 1'b0;
   logic [15:0] cmd_word_count = '0;
   logic [2:0]  cmd_context_max_id = '0;
   logic [31:0] cmd_run_cycles = '0;
   logic        cmd_abort = 1'b0;
   logic        cfg_valid_input = 1'b0;
   logic        cfg_stop_input;
   logic [4:0]  cfg_pe_id = '0;
   logic [2:0]  cfg_context_index = '0;
   logic [1:0]  cfg_in1 = '0, cfg_in2 = '0;
   logic [3:0]  cfg_out = '0, cfg_op = '0;
   logic [31:0] cfg_const = '0;
   logic [1:0]  c_in1, c_in2;
   logic [3:0]  c_out, c_op;
   logic [31:0] c_const;
   logic [2:0]  c_idx;
   logic [15:0] wcd;
   logic        start_exec, busy, done, err_bad_word;
   logic [2:0]  max_id_o;
`ifdef CONFIG_LOADER_PERF_EN
   logic [31:0] perf_run_cycles;
`endif

   elastic_config_loader #(.PE_NUM(16), .PE_ID_WIDTH(5)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_load(cmd_load), .cmd_word_count(cmd_word_count),
      .cmd_context_max_id(cmd_context_max_id), .cmd_run_cycles(cmd_run_cycles),
      .cmd_abort(cmd_abort), .cfg_valid_input(cfg_valid_input), .cfg_stop_input(cfg_stop_input),
      .cfg_pe_id(cfg_pe_id), .cfg_context_index(cfg_context_index),
      .cfg_input_PE_index_1(cfg_in1), .cfg_input_PE_index_2(cfg_in2),
      .cfg_output_PE_index(cfg_out), .cfg_op(cfg_op), .cfg_const_data(cfg_const),
      .config_input_PE_index_1(c_in1), .config_input_PE_index_2(c_in2),
      .config_output_PE_index(c_out), .config_op(c_op), .config_const_data(c_const),
      .config_index(c_idx), .write_config_data(wcd), .start_exec(start_exec),
      .mapping_context_max_id(max_id_o), .busy(busy), .done(done),
`ifdef CONFIG_LOADER_PERF_EN
      .perf_run_cycles(perf_run_cycles),
`endif
      .err_bad_word(err_bad_word));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] strobe;
      logic [2:0]  idx;
      logic [31:0] cdata;
   } exp_t;

   exp_t q[$];
   int total = 0, bad = 0;
   int cyc = 0;
   int n_start = 0, n_done = 0, t_start = 0, t_done = 0, n_strobe = 0;
   int last_t = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: compare every strobe against the scoreboard, record pulse timing.
   always @(negedge clk) begin
      if (reset_n && wcd != '0) begin
         exp_t e;
         n_strobe++;
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_strobe actual=%0h required=none", wcd);
         end else begin
            e = q.pop_front();
            chk("strobe", 64'(wcd), 64'(e.strobe));
            chk("bus_idx", 64'(c_idx), 64'(e.idx));
            chk("bus_const", 64'(c_const), 64'(e.cdata));
            chk("bus_fields", 64'({c_in1, c_in2, c_out, c_op}), 64'(e.cdata[11:0]));
         end
      end
      if (start_exec) begin n_start++; t_start = cyc; end
      if (done)       begin n_done++;  t_done  = cyc; end
   end

   task automatic load(input logic [15:0] cnt, input logic [2:0] mx, input logic [31:0] run);
      @(negedge clk);
      cmd_load = 1'b1; cmd_word_count = cnt; cmd_context_max_id = mx; cmd_run_cycles = run;
      @(negedge clk);
      cmd_load = 1'b0;
   endtask

   // Present one word and hold it until it transfers; exp_strobe==0 marks a bad word.
   task automatic send(input logic [4:0] pe, input logic [2:0] ctx, input logic [31:0] d,
                       input logic [15:0] exp_strobe);
      int b = 0;
      @(negedge clk);
      cfg_valid_input = 1'b1; cfg_pe_id = pe; cfg_context_index = ctx; cfg_const = d;
      cfg_in1 = d[11:10]; cfg_in2 = d[9:8]; cfg_out = d[7:4]; cfg_op = d[3:0];
      while (cfg_stop_input && b < 50) begin @(negedge clk); b++; end
      if (b >= 50) begin total++; bad++; $display("FAIL send_timeout actual=stop required=ready"); end
      last_t = cyc;
      if (exp_strobe != '0) q.push_back('{exp_strobe, ctx, d});
      @(posedge clk);
   endtask

   task automatic idle_valid();
      @(negedge clk); cfg_valid_input = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int b = 0;
      while (n_done == prev && b < 300) begin @(negedge clk); b++; end
      if (b >= 300) begin total++; bad++; $display("FAIL done_timeout actual=none required=pulse"); end
   endtask

   initial begin
      int s0, d0, st0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_stop", 64'(cfg_stop_input), 1);
      chk("rst_wcd", 64'(wcd), 0);
      chk("rst_err", 64'(err_bad_word), 0);
      chk("rst_start_done", 64'({start_exec, done}), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // 3 good words, back to back, run=10
      s0 = n_start; d0 = n_done;
      load(3, 2, 10);
      chk("busy_after_load", 64'(busy), 1);
      chk("max_id", 64'(max_id_o), 2);
      send(0, 0, 32'h0000_0A5C, 16'h0001);
      send(5, 1, 32'h1234_0B37, 16'h0020);
      send(15, 2, 32'hDEAD_BEEF, 16'h8000);
      idle_valid();
      wait_done(d0);
      chk("start_cnt1", 64'(n_start - s0), 1);
      chk("start_time", 64'(t_start), 64'(last_t + 2));
      chk("done_time", 64'(t_done), 64'(t_start + 11));
      @(negedge clk);
      chk("idle_after_done", 64'(busy), 0);
      chk("err_clean", 64'(err_bad_word), 0);
      chk("bus_hold", 64'(c_const), 64'h0000_0000_DEAD_BEEF);

      // valid toggled every other cycle
      d0 = n_done;
      load(3, 7, 2);
      send(1, 3, 32'h0000_0111, 16'h0002);
      idle_valid();
      send(2, 4, 32'h0000_0222, 16'h0004);
      idle_valid();
      send(3, 7, 32'h0000_0333, 16'h0008);
      idle_valid();
      wait_done(d0);
      chk("toggle_q_empty", 64'(q.size()), 0);

      // bad pe_id among good words
      d0 = n_done; st0 = n_strobe;
      load(3, 3, 4);
      send(3, 0, 32'h0000_0444, 16'h0008);
      send(16, 0, 32'h0000_0555, 16'h0000);
      send(7, 3, 32'h0000_0666, 16'h0080);
      idle_valid();
      wait_done(d0);
      chk("bad_err", 64'(err_bad_word), 1);
      chk("bad_strobes", 64'(n_strobe - st0), 2);

      // abort during LOAD after 1 of 4 words
      s0 = n_start; d0 = n_done; st0 = n_strobe;
      load(4, 1, 5);
      chk("err_cleared", 64'(err_bad_word), 0);
      send(9, 1, 32'h0000_0777, 16'h0200);
      @(negedge clk); cfg_valid_input = 1'b0; cmd_abort = 1'b1;
      @(negedge clk); cmd_abort = 1'b0;
      chk("abort_idle", 64'(busy), 0);
      chk("abort_stop", 64'(cfg_stop_input), 1);
      repeat (20) @(negedge clk);
      chk("abort_strobes", 64'(n_strobe - st0), 1);
      chk("abort_no_start_done", 64'({n_start - s0, n_done - d0}), 0);

      // abort together with last transfer: word strobed, no start
      s0 = n_start; st0 = n_strobe;
      load(1, 0, 3);
      @(negedge clk);
      cfg_valid_input = 1'b1; cfg_pe_id = 4; cfg_context_index = 0; cfg_const = 32'h0000_0888;
      cfg_in1 = 2'h2; cfg_in2 = 2'h0; cfg_out = 4'h8; cfg_op = 4'h8; cmd_abort = 1'b1;
      q.push_back('{16'h0010, 3'd0, 32'h0000_0888});
      @(negedge clk); cfg_valid_input = 1'b0; cmd_abort = 1'b0;
      chk("abort_last_idle", 64'(busy), 0);
      repeat (6) @(negedge clk);
      chk("abort_last_strobe", 64'(n_strobe - st0), 1);
      chk("abort_last_nostart", 64'(n_start - s0), 0);

      // run=0 persists until abort
      d0 = n_done; s0 = n_start;
      load(1, 0, 0);
      send(6, 0, 32'h0000_0999, 16'h0040);
      idle_valid();
      repeat (100) @(negedge clk);
      chk("run0_start", 64'(n_start - s0), 1);
      chk("run0_busy", 64'(busy), 1);
      cmd_abort = 1'b1;
      @(negedge clk); cmd_abort = 1'b0;
      chk("run0_abort_idle", 64'(busy), 0);
      repeat (5) @(negedge clk);
      chk("run0_no_done", 64'(n_done - d0), 0);

      // count==0 request
      load(0, 0, 5);
      chk("cnt0_err", 64'(err_bad_word), 1);
      chk("cnt0_busy", 64'(busy), 0);

`ifdef CONFIG_LOADER_PERF_EN
      d0 = n_done;
      load(1, 0, 7);
      send(2, 0, 32'h0000_0AAA, 16'h0004);
      idle_valid();
      wait_done(d0);
      @(negedge clk);
      chk("perf_run", 64'(perf_run_cycles), 7);
`endif

      // async reset mid-LOAD
      load(2, 0, 3);
      #2 reset_n = 1'b0;
      #1 chk("async_rst_busy", 64'(busy), 0);
      chk("async_rst_stop", 64'(cfg_stop_input), 1);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);

      chk("q_empty", 64'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
